// File: rtl/otter_decode_buf_if.sv
// Handshake bundle for otter_decode_buf.
//   master : fetch/execute side (drives flush, in_*, out_ready)
//   slave  : the decode buffer (drives in_ready, out_*)
// Optional OTTER_MEXT_EN adds out_mdu.
interface otter_decode_buf_if #(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned TAG_W = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [PC_W-1:0]   in_pc;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [TAG_W-1:0]  out_tag;
  logic [3:0]        out_alu_fun;
  logic              out_alu_srca;
  logic [1:0]        out_alu_srcb;
  logic [1:0]        out_rf_wr_sel;
  logic              out_rf_we;
  logic              out_mem_we;
  logic              out_mem_re;
  logic [2:0]        out_func3;
  logic [2:0]        out_pc_kind;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rd;
  logic              out_illegal;
`ifdef OTTER_MEXT_EN
  logic              out_mdu;
`endif

  modport master (
    output flush, in_valid, in_instr, in_pc, in_tag, out_ready,
    input  in_ready, out_valid, out_pc, out_tag, out_alu_fun, out_alu_srca,
           out_alu_srcb, out_rf_wr_sel, out_rf_we, out_mem_we, out_mem_re,
           out_func3, out_pc_kind, out_rs1, out_rs2, out_rd, out_illegal
`ifdef OTTER_MEXT_EN
    , input out_mdu
`endif
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, in_tag, out_ready,
    output in_ready, out_valid, out_pc, out_tag, out_alu_fun, out_alu_srca,
           out_alu_srcb, out_rf_wr_sel, out_rf_we, out_mem_we, out_mem_re,
           out_func3, out_pc_kind, out_rs1, out_rs2, out_rd, out_illegal
`ifdef OTTER_MEXT_EN
    , output out_mdu
`endif
  );
endinterface

// File: rtl/otter_decode_buf.sv
// OTTER instruction decoder feeding a small bundle FIFO.
// Ports: clk, rst (async, active-high), bus (otter_decode_buf_if.slave):
//   in_*  : instruction + pc + tag offered with valid/ready
//   out_* : head decoded bundle, popped with out_valid & out_ready
//   flush : drops everything buffered plus the same-cycle input
// Optional feature macro: OTTER_MEXT_EN (M-extension decode, out_mdu port).
module otter_decode_buf #(
  parameter int unsigned PC_W      = 32,
  parameter int unsigned BUF_DEPTH = 2,
  parameter int unsigned TAG_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  otter_decode_buf_if.slave  bus
);
  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [TAG_W-1:0] tag;
    logic [3:0]       alu_fun;
    logic             alu_srca;
    logic [1:0]       alu_srcb;
    logic [1:0]       rf_wr_sel;
    logic             rf_we;
    logic             mem_we;
    logic             mem_re;
    logic [2:0]       func3;
    logic [2:0]       pc_kind;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic             illegal;
`ifdef OTTER_MEXT_EN
    logic             mdu;
`endif
  } bundle_t;

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opcode = bus.in_instr[6:0];
  assign f3     = bus.in_instr[14:12];
  assign f7     = bus.in_instr[31:25];

  bundle_t dec_c;

  // Instruction decode; unknown opcodes (incl. instr[1:0] != 11) are illegal
  always_comb begin
    dec_c           = '0;
    dec_c.pc        = bus.in_pc;
    dec_c.tag       = bus.in_tag;
    dec_c.func3     = f3;
    dec_c.rs1       = bus.in_instr[19:15];
    dec_c.rs2       = bus.in_instr[24:20];
    dec_c.rd        = bus.in_instr[11:7];
    dec_c.rf_wr_sel = 2'd3;
    case (opcode)
      OPC_LUI: begin
        dec_c.alu_fun  = 4'b1001;
        dec_c.alu_srca = 1'b1;
        dec_c.rf_we    = 1'b1;
      end
      OPC_AUIPC: begin
        dec_c.alu_srca = 1'b1;
        dec_c.alu_srcb = 2'd3;
        dec_c.rf_we    = 1'b1;
      end
      OPC_JAL: begin
        dec_c.alu_srcb  = 2'd1;
        dec_c.rf_wr_sel = 2'd0;
        dec_c.pc_kind   = 3'd3;
        dec_c.rf_we     = 1'b1;
      end
      OPC_JALR: begin
        dec_c.rf_wr_sel = 2'd0;
        dec_c.pc_kind   = 3'd1;
        dec_c.rf_we     = 1'b1;
      end
      OPC_BRANCH: dec_c.pc_kind = 3'd2;
      OPC_LOAD: begin
        dec_c.alu_srcb  = 2'd1;
        dec_c.rf_wr_sel = 2'd2;
        dec_c.rf_we     = 1'b1;
        dec_c.mem_re    = 1'b1;
      end
      OPC_STORE: begin
        dec_c.alu_srcb = 2'd2;
        dec_c.mem_we   = 1'b1;
      end
      OPC_OP_IMM: begin
        // only shifts (f3=101) use f7[5] to pick srl/sra
        dec_c.alu_fun  = (f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
        dec_c.alu_srcb = 2'd1;
        dec_c.rf_we    = 1'b1;
      end
      OPC_OP: begin
        dec_c.alu_fun = {f7[5], f3};
        dec_c.rf_we   = 1'b1;
`ifdef OTTER_MEXT_EN
        if (f7 == 7'b0000001) begin
          dec_c.alu_fun = {1'b0, f3};
          dec_c.mdu     = 1'b1;
        end
`endif
      end
      OPC_SYSTEM: begin
        dec_c.alu_fun   = 4'b1001;
        dec_c.rf_wr_sel = 2'd1;
        dec_c.rf_we     = 1'b1;
        dec_c.pc_kind   = (f3 == 3'b000) ? 3'd5 : 3'd0;
      end
      default: dec_c.illegal = 1'b1;
    endcase
    if (dec_c.rd == 5'd0) dec_c.rf_we = 1'b0;
  end

  bundle_t          mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             in_ready_c;
  logic             out_valid_c;
  logic             push_c;
  logic             pop_c;
  bundle_t          head_c;

  assign in_ready_c  = (count < CNT_W'(BUF_DEPTH));
  assign out_valid_c = (count != '0);
  assign push_c      = bus.in_valid & in_ready_c;
  assign pop_c       = out_valid_c & bus.out_ready;

  // Pointer/count state; flush outranks any same-cycle push/pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Bundle storage needs no reset; empty slots are never shown
  always_ff @(posedge clk) begin
    if (push_c && !bus.flush) mem[wr_ptr] <= dec_c;
  end

  assign head_c = out_valid_c ? mem[rd_ptr] : '0;

  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = out_valid_c;
  assign bus.out_pc        = head_c.pc;
  assign bus.out_tag       = head_c.tag;
  assign bus.out_alu_fun   = head_c.alu_fun;
  assign bus.out_alu_srca  = head_c.alu_srca;
  assign bus.out_alu_srcb  = head_c.alu_srcb;
  assign bus.out_rf_wr_sel = head_c.rf_wr_sel;
  assign bus.out_rf_we     = head_c.rf_we;
  assign bus.out_mem_we    = head_c.mem_we;
  assign bus.out_mem_re    = head_c.mem_re;
  assign bus.out_func3     = head_c.func3;
  assign bus.out_pc_kind   = head_c.pc_kind;
  assign bus.out_rs1       = head_c.rs1;
  assign bus.out_rs2       = head_c.rs2;
  assign bus.out_rd        = head_c.rd;
  assign bus.out_illegal   = head_c.illegal;
`ifdef OTTER_MEXT_EN
  assign bus.out_mdu       = head_c.mdu;
`endif
endmodule

// File: tb/tb_otter_decode_buf.sv
// Bench for otter_decode_buf: directed literal checks plus randomized traffic
// against a queue-based reference model compared every cycle.
module tb_otter_decode_buf;
  localparam int unsigned PC_W  = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned TAG_W = 4;
`ifdef OTTER_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  otter_decode_buf_if #(.PC_W(PC_W), .TAG_W(TAG_W)) bus ();

  otter_decode_buf #(.PC_W(PC_W), .BUF_DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  tag;
    logic [3:0]  alu_fun;
    logic        srca;
    logic [1:0]  srcb;
    logic [1:0]  wr_sel;
    logic        rf_we;
    logic        mem_we;
    logic        mem_re;
    logic [2:0]  func3;
    logic [2:0]  pc_kind;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        illegal;
    logic        mdu;
  } exp_t;

  int total = 0;
  int bad   = 0;
  exp_t q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Field-by-field reference decode from the opcode's mnemonic
  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [3:0] tag);
    exp_t  e;
    string k;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    logic [6:0] f7 = ins[31:25];
    k = (op == 7'h37) ? "LUI"   : (op == 7'h17) ? "AUIPC" : (op == 7'h6F) ? "JAL" :
        (op == 7'h67) ? "JALR"  : (op == 7'h63) ? "BRANCH": (op == 7'h03) ? "LOAD" :
        (op == 7'h23) ? "STORE" : (op == 7'h13) ? "OPIMM" : (op == 7'h33) ? "OP" :
        (op == 7'h73) ? "SYSTEM": "BAD";
    e.pc = pc; e.tag = tag; e.func3 = f3;
    e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
    e.illegal = (k == "BAD");
    e.mdu = (k == "OP") && MEXT && (f7 == 7'b0000001);
    if (e.mdu)                        e.alu_fun = {1'b0, f3};
    else if (k == "OP")               e.alu_fun = {f7[5], f3};
    else if (k == "OPIMM")            e.alu_fun = (f3 == 3'b101) ? {f7[5], f3} : {1'b0, f3};
    else if (k == "LUI" || k == "SYSTEM") e.alu_fun = 4'b1001;
    else                              e.alu_fun = 4'b0000;
    e.srca   = (k == "LUI" || k == "AUIPC");
    e.srcb   = (k == "STORE") ? 2'd2 : (k == "LOAD" || k == "JAL" || k == "OPIMM") ? 2'd1 :
               (k == "AUIPC") ? 2'd3 : 2'd0;
    e.wr_sel = (k == "JAL" || k == "JALR") ? 2'd0 : (k == "SYSTEM") ? 2'd1 :
               (k == "LOAD") ? 2'd2 : 2'd3;
    e.pc_kind = (k == "JAL") ? 3'd3 : (k == "JALR") ? 3'd1 : (k == "BRANCH") ? 3'd2 :
                (k == "SYSTEM" && f3 == 3'b000) ? 3'd5 : 3'd0;
    e.rf_we  = !(k == "BRANCH" || k == "STORE" || k == "BAD") && (e.rd != 5'd0);
    e.mem_we = (k == "STORE");
    e.mem_re = (k == "LOAD");
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w = $urandom;
    case ($urandom_range(0, 11))
      0:  w[6:0] = 7'h37;
      1:  w[6:0] = 7'h17;
      2:  w[6:0] = 7'h6F;
      3:  w[6:0] = 7'h67;
      4:  w[6:0] = 7'h63;
      5:  w[6:0] = 7'h03;
      6:  w[6:0] = 7'h23;
      7:  w[6:0] = 7'h13;
      8:  w[6:0] = 7'h33;
      9:  w[6:0] = 7'h73;
      10: begin w[6:0] = 7'h33; w[31:25] = 7'b0000001; end
      default: ;
    endcase
    return w;
  endfunction

  // Reference FIFO: pop head if consumer ready, push if room existed before the edge
  always @(posedge clk or posedge rst) begin : model
    int sz;
    if (rst || bus.flush) begin
      q.delete();
    end else begin
      sz = q.size();
      if (sz != 0 && bus.out_ready) void'(q.pop_front());
      if (bus.in_valid && sz < DEPTH) q.push_back(model_decode(bus.in_instr, bus.in_pc, bus.in_tag));
    end
  end

  task automatic cmp_head(input exp_t e);
    chk("pc", bus.out_pc, e.pc);
    chk("tag", bus.out_tag, e.tag);
    chk("illegal", bus.out_illegal, e.illegal);
    chk("rf_we", bus.out_rf_we, e.rf_we);
    chk("mem_we", bus.out_mem_we, e.mem_we);
    chk("mem_re", bus.out_mem_re, e.mem_re);
    chk("pc_kind", bus.out_pc_kind, e.pc_kind);
    if (!e.illegal) begin
      chk("alu_fun", bus.out_alu_fun, e.alu_fun);
      chk("alu_srca", bus.out_alu_srca, e.srca);
      chk("alu_srcb", bus.out_alu_srcb, e.srcb);
      chk("rf_wr_sel", bus.out_rf_wr_sel, e.wr_sel);
      chk("func3", bus.out_func3, e.func3);
      chk("rs1", bus.out_rs1, e.rs1);
      chk("rs2", bus.out_rs2, e.rs2);
      chk("rd", bus.out_rd, e.rd);
`ifdef OTTER_MEXT_EN
      chk("mdu", bus.out_mdu, e.mdu);
`endif
    end
  endtask

  // Per-cycle compare, away from the rising edge
  always @(negedge clk) begin
    chk("in_ready", bus.in_ready, q.size() < DEPTH);
    chk("out_valid", bus.out_valid, q.size() != 0);
    if (q.size() != 0) cmp_head(q[0]);
    else chk("empty_fields", |{bus.out_pc, bus.out_tag, bus.out_alu_fun, bus.out_alu_srca,
                                bus.out_alu_srcb, bus.out_rf_wr_sel, bus.out_rf_we,
                                bus.out_mem_we, bus.out_mem_re, bus.out_func3,
                                bus.out_pc_kind, bus.out_rs1, bus.out_rs2, bus.out_rd,
                                bus.out_illegal}, 1'b0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction for one cycle; returns just after the push edge
  task automatic send1(input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid = 1'b1; bus.in_instr = ins; bus.in_pc = pc; bus.in_tag = 4'h5;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0;
    bus.in_tag = '0; bus.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_out_valid", bus.out_valid, 1'b0);
    tick();

    // addi x1,x0,5
    bus.out_ready = 1'b1;
    send1(32'h00500093, 32'h100);
    chk("addi_valid", bus.out_valid, 1'b1);
    chk("addi_alu", bus.out_alu_fun, 4'b0000);
    chk("addi_srcb", bus.out_alu_srcb, 2'd1);
    chk("addi_wrsel", bus.out_rf_wr_sel, 2'd3);
    chk("addi_we", bus.out_rf_we, 1'b1);
    chk("addi_rd", bus.out_rd, 5'd1);
    chk("addi_pc", bus.out_pc, 32'h100);

    send1(32'h40208133, 32'h104);
    chk("sub_alu", bus.out_alu_fun, 4'b1000);
    chk("sub_srcb", bus.out_alu_srcb, 2'd0);
    send1(32'h0000A103, 32'h108);
    chk("lw_wrsel", bus.out_rf_wr_sel, 2'd2);
    chk("lw_re", bus.out_mem_re, 1'b1);
    chk("lw_srcb", bus.out_alu_srcb, 2'd1);
    send1(32'h00112023, 32'h10C);
    chk("sw_we", bus.out_mem_we, 1'b1);
    chk("sw_srcb", bus.out_alu_srcb, 2'd2);
    chk("sw_rfwe", bus.out_rf_we, 1'b0);
    tick();

    // Back-pressure: fill with two, third waits for out_ready
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 32'h00100093; bus.in_pc = 32'h200;
    tick();
    chk("bp_ready1", bus.in_ready, 1'b1);
    bus.in_instr = 32'h00200093; bus.in_pc = 32'h204;
    tick();
    chk("bp_full", bus.in_ready, 1'b0);
    bus.in_instr = 32'h00300093; bus.in_pc = 32'h208;
    tick();
    chk("bp_hold_pc", bus.out_pc, 32'h200);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_head2", bus.out_pc, 32'h204);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_head3", bus.out_pc, 32'h208);
    tick();

    send1(32'h0000006F, 32'h300);
    chk("jal_kind", bus.out_pc_kind, 3'd3);
    chk("jal_we", bus.out_rf_we, 1'b0);
    send1(32'h00000063, 32'h304);
    chk("beq_kind", bus.out_pc_kind, 3'd2);
    chk("beq_f3", bus.out_func3, 3'b000);
    send1(32'h30200073, 32'h308);
    chk("mret_kind", bus.out_pc_kind, 3'd5);
    send1(32'hFFFFFFFF, 32'h30C);
    chk("ill_flag", bus.out_illegal, 1'b1);
    chk("ill_enables", {bus.out_rf_we, bus.out_mem_we, bus.out_mem_re}, 3'b000);
    chk("ill_kind", bus.out_pc_kind, 3'd0);
    send1(32'h022081B3, 32'h310);
    chk("mul_alu", bus.out_alu_fun, 4'b0000);
    chk("mul_rd", bus.out_rd, 5'd3);
    chk("mul_ill", bus.out_illegal, 1'b0);
`ifdef OTTER_MEXT_EN
    chk("mul_mdu", bus.out_mdu, 1'b1);
`endif
    tick();

    // Flush with a full buffer, then with one entry and a live push
    bus.out_ready = 1'b0;
    send1(32'h00100093, 32'h400);
    send1(32'h00200093, 32'h404);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_instr = 32'h00300093;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_valid", bus.out_valid, 1'b0);
    chk("flush_ready", bus.in_ready, 1'b1);
    send1(32'h00400093, 32'h410);
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    tick();
    chk("flush_input_absent", bus.out_valid, 1'b0);

    // Asynchronous reset mid-stream
    bus.out_ready = 1'b0;
    send1(32'h00500093, 32'h500);
    send1(32'h00600093, 32'h504);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", bus.out_valid, 1'b0);
    chk("rst_async_ready", bus.in_ready, 1'b1);
    tick();
    rst = 1'b0;
    tick();

    // Randomized traffic with phases of differing back-pressure
    for (int i = 0; i < 3000; i++) begin
      int bias = ((i / 250) % 2 == 0) ? 70 : 25;
      bus.in_valid  = ($urandom_range(0, 99) < 60);
      bus.out_ready = ($urandom_range(0, 99) < bias);
      bus.in_instr  = rand_instr();
      bus.in_pc     = $urandom;
      bus.in_tag    = 4'($urandom);
      bus.flush     = ($urandom_range(0, 99) < 3);
      rst           = ($urandom_range(0, 399) == 0);
      tick();
    end
    rst = 1'b0; bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
